denormal: RTL and testbench
===========================

DENORMAL -- requirements
Module: denormal

Interface
REQ-001 The block SHALL expose the following ports, one per line (name, direction, width, meaning); one clock, reset asynchronous and active-high:
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous active-high reset
- IN_VALID  in  1  operand offered
- IN_READY  out  1  block can accept operand
- IN  in  24  mantissa with hidden bit at [23]
- SHAMT  in  8  right-shift amount (unsigned)
- EXPIN  in  8  exponent of operand
- OUT_VALID  out  1  result available
- OUT_READY  in  1  consumer accepts result
- OUT  out  24  aligned mantissa
- GRS  out  3  guard/round/sticky, [2]=G [1]=R [0]=S
- EXPOUT  out  8  EXPIN+SHAMT, modulo 256
- EXPOF  out  1  carry out of EXPIN+SHAMT
- ZEROFLAG  out  1  accepted IN was all-zero

Function
REQ-002 The FSM SHALL have states IDLE, SHIFT, DONE; IN_READY=1 only in IDLE; OUT_VALID=1 only in DONE.
REQ-003 Accept when IN_VALID=1 in IDLE: load 27-bit working register W={IN,3'b000}, latch CNT=min(SHAMT,27), and capture the 9-bit sum EXPIN+SHAMT and ZEROFLAG=(IN==0).
REQ-004 From IDLE after accept, the FSM SHALL go to DONE if CNT=0, else to SHIFT.
REQ-005 Each SHIFT cycle SHALL update W <= {1'b0, W[26:2], W[1]|W[0]} and decrement CNT; on the cycle CNT goes 1->0 the FSM SHALL go to DONE.
REQ-006 Latency: OUT_VALID SHALL rise 1 cycle after accept for SHAMT=0, and min(SHAMT,27)+1 cycles after accept otherwise.
REQ-007 SHAMT>=27 SHALL saturate at 27 shifts; the result is OUT=0, G=R=0, S=OR of all IN bits.
REQ-008 OUT=W[26:3] and GRS=W[2:0]; EXPOUT/EXPOF are the low 8 bits and carry of the 9-bit sum; all outputs registered.
REQ-009 In DONE, all outputs SHALL hold stable while OUT_READY=0; on OUT_READY=1 the FSM returns to IDLE, and OUT_VALID drops the next cycle.
REQ-010 An IN_VALID that coincides with the DONE->IDLE handoff SHALL NOT be accepted in that cycle (IN_READY=0); it is accepted the following cycle.
REQ-011 Input ports SHALL be ignored outside IDLE; the latched operand is not affected by changes on IN/SHAMT/EXPIN.

Reset
REQ-012 RST=1 SHALL asynchronously force state IDLE, W=0, CNT=0, OUT=0, GRS=0, EXPOUT=0, EXPOF=0, ZEROFLAG=0, OUT_VALID=0, IN_READY=1.
REQ-013 Reset during SHIFT or DONE SHALL discard the in-flight operand with no result emitted; the first accept after release begins a fresh operation.

Structure
REQ-014 A shared package fp_pkg SHALL hold MANT_W=24, EXP_W=8, GRS_W=3, SHIFT_SAT=27 and the state enum (IDLE/SHIFT/DONE).
REQ-015 The block SHALL be a single module with no sub-module; the FSM, down-counter and sticky shift register live in denormal.

Verification
REQ-016 IN=24'h800000, SHAMT=0, EXPIN=100 -> OUT_VALID 1 cycle after accept, OUT=24'h800000, GRS=3'b000, EXPOUT=100, EXPOF=0, ZEROFLAG=0.
REQ-017 IN=24'hC00001, SHAMT=3, EXPIN=10 -> OUT_VALID 4 cycles after accept, OUT=24'h180000, GRS=3'b001, EXPOUT=13.
REQ-018 IN=24'hFFFFFF, SHAMT=200, EXPIN=100 -> OUT_VALID 28 cycles after accept, OUT=0, GRS=3'b001, EXPOUT=44, EXPOF=1.
REQ-019 OUT_READY held 0 for 5 cycles in DONE -> OUT/GRS/EXPOUT stable, IN_READY=0 throughout, and a new IN_VALID is not accepted.
REQ-020 RST pulsed mid-SHIFT (SHAMT=20, at cycle 5) -> same cycle: IN_READY=1, OUT_VALID=0, all outputs 0; no stale result afterwards.
REQ-021 IN=0, SHAMT=2 -> OUT=0, GRS=0, ZEROFLAG=1, OUT_VALID 3 cycles after accept.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared floating-point alignment definitions.
// Holds datapath widths, the shift saturation limit, the denormalizer
// state enum and a helper that clamps a requested shift amount.
package fp_pkg;

    localparam int MANT_W    = 24;                // mantissa incl. hidden bit
    localparam int EXP_W     = 8;                 // exponent / shift-amount width
    localparam int GRS_W     = 3;                 // guard, round, sticky
    localparam int SHIFT_SAT = 27;                // shifting further only feeds sticky
    localparam int W_W       = MANT_W + GRS_W;    // working register width
    localparam int CNT_W     = 5;                 // holds 0..SHIFT_SAT

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // Beyond SHIFT_SAT every mantissa bit has already collapsed into sticky,
    // so larger requests behave identically to SHIFT_SAT.
    function automatic logic [CNT_W-1:0] sat_shift(input logic [EXP_W-1:0] shamt);
        if (shamt >= EXP_W'(SHIFT_SAT)) begin
            return CNT_W'(SHIFT_SAT);
        end
        return shamt[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/denormal.sv
// denormal: right-aligns a mantissa by SHAMT bit positions, one position
// per clock, folding shifted-out bits into a sticky bit, and adds SHAMT
// to the exponent.
//
// Ports:
//   CLK        rising-edge clock
//   RST        asynchronous active-high reset
//   IN_VALID   operand offered          IN_READY   block can accept operand
//   IN         mantissa, hidden bit [23]
//   SHAMT      right-shift amount       EXPIN      operand exponent
//   OUT_VALID  result available         OUT_READY  consumer accepts result
//   OUT        aligned mantissa         GRS        {guard, round, sticky}
//   EXPOUT     (EXPIN+SHAMT) mod 256    EXPOF      carry of EXPIN+SHAMT
//   ZEROFLAG   accepted IN was zero
module denormal
    import fp_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [MANT_W-1:0] IN,
    input  logic [EXP_W-1:0]  SHAMT,
    input  logic [EXP_W-1:0]  EXPIN,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [MANT_W-1:0] OUT,
    output logic [GRS_W-1:0]  GRS,
    output logic [EXP_W-1:0]  EXPOUT,
    output logic              EXPOF,
    output logic              ZEROFLAG
);

    state_t           state;
    state_t           state_nx;
    logic [W_W-1:0]   w;        // {mantissa, G, R, S} working register
    logic [CNT_W-1:0] cnt;      // shifts still to perform
    logic [EXP_W:0]   sum;      // 9-bit exponent sum incl. carry
    logic             zero_q;
    logic             accept;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and handshake decode.
    // NOTE: every output of this block is given a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nx  = state;
        IN_READY  = 1'b0;
        OUT_VALID = 1'b0;
        case (state)
            IDLE: begin
                IN_READY = 1'b1;
                if (IN_VALID) begin
                    // A zero shift needs no SHIFT cycles at all.
                    state_nx = (SHAMT == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                // The last shift is performed on the same edge that enters DONE.
                if (cnt == CNT_W'(1)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                OUT_VALID = 1'b1;
                if (OUT_READY) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign accept = IN_READY & IN_VALID;

    // Datapath: operand capture, sticky shift and down-counter. Inputs are
    // only sampled on accept, so they are free to change at any other time.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            w      <= '0;
            cnt    <= '0;
            sum    <= '0;
            zero_q <= 1'b0;
        end else if (accept) begin
            w      <= {IN, {GRS_W{1'b0}}};
            cnt    <= sat_shift(SHAMT);
            sum    <= {1'b0, EXPIN} + {1'b0, SHAMT};
            zero_q <= (IN == '0);
        end else if (state == SHIFT) begin
            // Bit 0 keeps the OR of everything that ever passed through it.
            w   <= {1'b0, w[W_W-1:2], w[1] | w[0]};
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign OUT      = w[W_W-1:GRS_W];
    assign GRS      = w[GRS_W-1:0];
    assign EXPOUT   = sum[EXP_W-1:0];
    assign EXPOF    = sum[EXP_W];
    assign ZEROFLAG = zero_q;

endmodule

// File: tb/tb_denormal.sv
// Testbench for denormal: directed and random operands, a scoreboard queue
// filled on accept, and a monitor that checks each presented result, its
// latency, and that outputs hold steady while the consumer stalls.
module tb_denormal;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IN_VALID;
    logic        IN_READY;
    logic [23:0] IN;
    logic [7:0]  SHAMT;
    logic [7:0]  EXPIN;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [23:0] OUT;
    logic [2:0]  GRS;
    logic [7:0]  EXPOUT;
    logic        EXPOF;
    logic        ZEROFLAG;

    denormal dut (
        .CLK(CLK), .RST(RST),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN(IN), .SHAMT(SHAMT), .EXPIN(EXPIN),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT(OUT), .GRS(GRS), .EXPOUT(EXPOUT), .EXPOF(EXPOF), .ZEROFLAG(ZEROFLAG)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [23:0] out;
        logic [2:0]  grs;
        logic [7:0]  expout;
        logic        expof;
        logic        zf;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   hold_ready = 1'b0;

    always @(posedge CLK) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: shifting right n places while OR-ing everything dropped
    // into the lowest bit, expressed as one big shift plus a mask test.
    function automatic exp_t model(input logic [23:0] in_v, input logic [7:0] sh, input logic [7:0] ex);
        exp_t e;
        int n;
        int s;
        logic [63:0] ext;
        logic [63:0] r;
        n   = (sh > 27) ? 27 : int'(sh);
        ext = {40'd0, in_v, 3'b000};
        r   = ext >> n;
        if (n > 0 && (ext & ((64'd1 << n) - 64'd1)) != 64'd0) r[0] = 1'b1;
        s        = int'(ex) + int'(sh);
        e.out    = r[26:3];
        e.grs    = r[2:0];
        e.expout = 8'(s % 256);
        e.expof  = (s >= 256);
        e.zf     = (in_v == 24'd0);
        e.lat    = n + 1;
        e.acc    = 0;
        return e;
    endfunction

    // Monitor and consumer: checks at the falling edge, then decides
    // OUT_READY for the coming rising edge.
    initial begin
        exp_t cur;
        bit presenting = 1'b0;
        bit hs = 1'b0;
        OUT_READY = 1'b0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                presenting = 1'b0;
                hs = 1'b0;
                OUT_READY = 1'b0;
                continue;
            end
            if (hs) begin
                check("valid_drop_after_take", 32'(OUT_VALID), 32'd0);
                check("ready_after_take", 32'(IN_READY), 32'd1);
                hs = 1'b0;
                presenting = 1'b0;
            end
            if (OUT_VALID) begin
                if (!presenting) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got OUT=%h GRS=%b with nothing expected", OUT, GRS);
                        cur.out = OUT; cur.grs = GRS; cur.expout = EXPOUT;
                        cur.expof = EXPOF; cur.zf = ZEROFLAG;
                    end else begin
                        cur = sb.pop_front();
                        check("latency", 32'(cyc - cur.acc + 1), 32'(cur.lat));
                    end
                    presenting = 1'b1;
                end
                check("out",      32'(OUT),      32'(cur.out));
                check("grs",      32'(GRS),      32'(cur.grs));
                check("expout",   32'(EXPOUT),   32'(cur.expout));
                check("expof",    32'(EXPOF),    32'(cur.expof));
                check("zeroflag", 32'(ZEROFLAG), 32'(cur.zf));
                check("in_ready_in_done", 32'(IN_READY), 32'd0);
                OUT_READY = hold_ready ? 1'b0 : ($urandom_range(0, 2) != 0);
                hs = OUT_READY;
            end else begin
                OUT_READY = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic send(input logic [23:0] in_v, input logic [7:0] sh, input logic [7:0] ex);
        exp_t e;
        int waitc = 0;
        @(negedge CLK);
        IN = in_v; SHAMT = sh; EXPIN = ex; IN_VALID = 1'b1;
        while (!IN_READY) begin
            waitc++;
            if (waitc > 300) begin
                check("accept_timeout", 32'd0, 32'd1);
                IN_VALID = 1'b0;
                return;
            end
            @(negedge CLK);
        end
        e = model(in_v, sh, ex);
        e.acc = cyc + 1;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        // Scramble inputs after capture; the latched operand must not care.
        IN_VALID = 1'b0;
        IN = 24'($urandom); SHAMT = 8'($urandom); EXPIN = 8'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || OUT_VALID) && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        check("drain_timeout", 32'(n >= 2000), 32'd0);
    endtask

    initial begin
        logic [23:0] rin;
        logic [7:0]  rsh;
        int          n;
        IN_VALID = 1'b0; IN = '0; SHAMT = '0; EXPIN = '0;
        RST = 1'b0;
        #2 RST = 1'b1;
        #2;
        check("rst_in_ready",  32'(IN_READY),  32'd1);
        check("rst_out_valid", 32'(OUT_VALID), 32'd0);
        check("rst_out",       32'(OUT),       32'd0);
        check("rst_grs",       32'(GRS),       32'd0);
        check("rst_expout",    32'(EXPOUT),    32'd0);
        check("rst_expof",     32'(EXPOF),     32'd0);
        check("rst_zeroflag",  32'(ZEROFLAG),  32'd0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;

        // Directed vectors.
        send(24'h800000, 8'd0,   8'd100);
        send(24'hC00001, 8'd3,   8'd10);
        send(24'hFFFFFF, 8'd200, 8'd100);
        send(24'h000000, 8'd2,   8'd7);
        send(24'h800001, 8'd27,  8'd255);
        send(24'hABCDEF, 8'd26,  8'd1);
        drain();

        // Consumer stall with a competing operand held on the inputs,
        // then that operand offered straight across the handoff.
        hold_ready = 1'b1;
        send(24'h9F0F0F, 8'd5, 8'd250);
        n = 0;
        while (!OUT_VALID && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check("stall_reach_done", 32'(OUT_VALID), 32'd1);
        repeat (5) begin
            @(negedge CLK);
            IN_VALID = 1'b1;
            IN = 24'($urandom); SHAMT = 8'($urandom); EXPIN = 8'($urandom);
            check("stall_in_ready", 32'(IN_READY), 32'd0);
        end
        hold_ready = 1'b0;
        send(24'h812345, 8'd4, 8'd20);
        drain();

        // Reset in the middle of a long shift.
        send(24'hF00F0F, 8'd20, 8'd50);
        repeat (5) @(negedge CLK);
        RST = 1'b1;
        #1;
        check("mid_rst_in_ready",  32'(IN_READY),  32'd1);
        check("mid_rst_out_valid", 32'(OUT_VALID), 32'd0);
        check("mid_rst_out",       32'(OUT),       32'd0);
        check("mid_rst_grs",       32'(GRS),       32'd0);
        check("mid_rst_expout",    32'(EXPOUT),    32'd0);
        check("mid_rst_expof",     32'(EXPOF),     32'd0);
        check("mid_rst_zeroflag",  32'(ZEROFLAG),  32'd0);
        sb.delete();
        @(negedge CLK);
        RST = 1'b0;
        repeat (30) @(negedge CLK);
        send(24'h800003, 8'd1, 8'd9);
        drain();

        // Random operands, biased toward the zero, in-range and saturated cases.
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0:       rsh = 8'd0;
                1:       rsh = 8'($urandom_range(1, 26));
                2:       rsh = 8'($urandom_range(27, 255));
                default: rsh = 8'($urandom);
            endcase
            if ($urandom_range(0, 7) == 0) rin = 24'd0;
            else                           rin = {1'b1, 23'($urandom)};
            send(rin, rsh, 8'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge CLK);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
